cpu_run_ctrl: RTL and testbench

//  Run sequencer and data-memory arbiter for the CPU top level. Holds the core in

---
 rtl/cpu_run_ctrl_pkg.sv | 19 +
 rtl/cpu_run_ctrl_if.sv | 22 ++
 rtl/cpu_run_ctrl_data_mem_mux.sv | 41 ++++
 rtl/cpu_run_ctrl.sv | 118 +++++++++++
 tb/tb_cpu_run_ctrl.sv | 280 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/cpu_run_ctrl_pkg.sv
// Shared types and constants for the CPU run sequencer / data-memory arbiter.
package cpu_run_ctrl_pkg;

    localparam int MEM_W = 8;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_PRESET,
        ST_RUN,
        ST_DONE,
        ST_TIMEOUT
    } run_state_e;

    // States in which the host owns the data-memory port and may start a run.
    function automatic logic is_host_state(input run_state_e s);
        return (s == ST_IDLE) || (s == ST_DONE) || (s == ST_TIMEOUT);
    endfunction

endpackage

// File: rtl/cpu_run_ctrl_if.sv
// Host load/unload port: request/ack handshake onto the shared data memory.
interface cpu_run_ctrl_if;
    import cpu_run_ctrl_pkg::*;

    logic             host_mem_req;
    logic             host_mem_we;
    logic [MEM_W-1:0] host_mem_addr;
    logic [MEM_W-1:0] host_mem_wdata;
    logic [MEM_W-1:0] host_mem_rdata;
    logic             host_mem_ack;

    modport master (
        output host_mem_req, host_mem_we, host_mem_addr, host_mem_wdata,
        input  host_mem_rdata, host_mem_ack
    );

    modport slave (
        input  host_mem_req, host_mem_we, host_mem_addr, host_mem_wdata,
        output host_mem_rdata, host_mem_ack
    );

endinterface

// File: rtl/cpu_run_ctrl_data_mem_mux.sv
// Combinational owner select for the single data-memory port: core during RUN,
// host only in a cycle where an access is accepted, otherwise everything idle.
module data_mem_mux
    import cpu_run_ctrl_pkg::*;
(
    input  logic             is_run,
    input  logic             accept,
    input  logic             host_we,
    input  logic [MEM_W-1:0] host_addr,
    input  logic [MEM_W-1:0] host_wdata,
    input  logic [MEM_W-1:0] cpu_addr,
    input  logic             cpu_read,
    input  logic             cpu_write,
    input  logic [MEM_W-1:0] cpu_wdata,
    output logic [MEM_W-1:0] mem_addr,
    output logic             mem_read,
    output logic             mem_write,
    output logic [MEM_W-1:0] mem_wdata
);

    // Route the core or an accepted host access onto the memory port.
    always_comb begin
        // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
        mem_addr  = '0;
        mem_read  = 1'b0;
        mem_write = 1'b0;
        mem_wdata = '0;
        if (is_run) begin
            mem_addr  = cpu_addr;
            mem_read  = cpu_read;
            mem_write = cpu_write;
            mem_wdata = cpu_wdata;
        end else if (accept) begin
            mem_addr  = host_addr;
            mem_read  = !host_we;
            mem_write = host_we;
            mem_wdata = host_wdata;
        end
    end

endmodule

// File: rtl/cpu_run_ctrl.sv
// Run sequencer: holds the core in reset, releases it for a run, counts run
// cycles, stops on halt or timeout, and arbitrates data memory with the host.
module cpu_run_ctrl
    import cpu_run_ctrl_pkg::*;
#(
    parameter int                RESET_CYCLES = 2,
    parameter int                CW           = 32,
    parameter longint unsigned   TIMEOUT      = 1_000_000
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 host_go,
    cpu_run_ctrl_if.slave        host,
    output logic                 cpu_start,
    input  logic                 cpu_halt,
    input  logic [MEM_W-1:0]     cpu_mem_addr,
    input  logic                 cpu_mem_read,
    input  logic                 cpu_mem_write,
    input  logic [MEM_W-1:0]     cpu_mem_wdata,
    output logic [MEM_W-1:0]     mem_addr,
    output logic                 mem_read,
    output logic                 mem_write,
    output logic [MEM_W-1:0]     mem_wdata,
    input  logic [MEM_W-1:0]     mem_rdata,
    output logic                 busy,
    output logic                 done,
    output logic                 timeout,
    output logic [CW-1:0]        cycle_count
);

    localparam int            PW          = $clog2(RESET_CYCLES + 1);
    localparam logic [PW-1:0] PRESET_LAST = PW'(RESET_CYCLES - 1);
    localparam logic [CW-1:0] TIMEOUT_CNT = CW'(TIMEOUT);

    run_state_e    state, state_nx;
    logic [PW-1:0] preset_cnt;
    logic [CW-1:0] count_inc;
    logic          accept;
    logic          start_run;

    assign count_inc = cycle_count + CW'(1);

    // State register.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignment so all flops update together.
        if (reset) state <= ST_IDLE;
        else       state <= state_nx;
    end

    // Next-state decode and host access acceptance.
    always_comb begin
        state_nx  = state;
        accept    = 1'b0;
        start_run = 1'b0;
        unique case (state)
            ST_IDLE, ST_DONE, ST_TIMEOUT: begin
                // go wins over a same-cycle request; the request stays pending.
                if (host_go && !host.host_mem_ack) begin
                    state_nx  = ST_PRESET;
                    start_run = 1'b1;
                end else if (host.host_mem_req && !host.host_mem_ack) begin
                    accept = 1'b1;
                end
            end
            ST_PRESET: if (preset_cnt == PRESET_LAST) state_nx = ST_RUN;
            ST_RUN: begin
                // halt has priority over a timeout in the same cycle
                if (cpu_halt)                      state_nx = ST_DONE;
                else if (count_inc == TIMEOUT_CNT) state_nx = ST_TIMEOUT;
            end
            default: state_nx = ST_IDLE;
        endcase
    end

    // Counters, host ack pulse and captured read data.
    always_ff @(posedge clk) begin
        if (reset) begin
            cycle_count         <= '0;
            preset_cnt          <= '0;
            host.host_mem_ack   <= 1'b0;
            host.host_mem_rdata <= '0;
        end else begin
            host.host_mem_ack <= accept;
            if (accept && !host.host_mem_we) host.host_mem_rdata <= mem_rdata;
            if (start_run) begin
                cycle_count <= '0;
                preset_cnt  <= '0;
            end else if (state == ST_PRESET) begin
                preset_cnt <= preset_cnt + PW'(1);
            end else if (state == ST_RUN && !cpu_halt) begin
                cycle_count <= count_inc;
            end
        end
    end

    // Status and core reset decoded from registered state only.
    assign cpu_start = (state != ST_RUN);
    assign busy      = (state == ST_PRESET) || (state == ST_RUN);
    assign done      = (state == ST_DONE);
    assign timeout   = (state == ST_TIMEOUT);

    data_mem_mux u_mux (
        .is_run     (state == ST_RUN),
        .accept     (accept),
        .host_we    (host.host_mem_we),
        .host_addr  (host.host_mem_addr),
        .host_wdata (host.host_mem_wdata),
        .cpu_addr   (cpu_mem_addr),
        .cpu_read   (cpu_mem_read),
        .cpu_write  (cpu_mem_write),
        .cpu_wdata  (cpu_mem_wdata),
        .mem_addr   (mem_addr),
        .mem_read   (mem_read),
        .mem_write  (mem_write),
        .mem_wdata  (mem_wdata)
    );

endmodule

// File: tb/tb_cpu_run_ctrl.sv
// Directed bench for cpu_run_ctrl with a behavioural data memory and a
// hand-driven core (halt / memory strobes). TIMEOUT is shortened to 100.
module tb_cpu_run_ctrl;
    import cpu_run_ctrl_pkg::*;

    logic             clk = 1'b0;
    logic             reset;
    logic             host_go;
    logic             cpu_start;
    logic             cpu_halt;
    logic [MEM_W-1:0] cpu_mem_addr;
    logic             cpu_mem_read;
    logic             cpu_mem_write;
    logic [MEM_W-1:0] cpu_mem_wdata;
    logic [MEM_W-1:0] mem_addr;
    logic             mem_read;
    logic             mem_write;
    logic [MEM_W-1:0] mem_wdata;
    logic [MEM_W-1:0] mem_rdata;
    logic             busy;
    logic             done;
    logic             timeout;
    logic [31:0]      cycle_count;

    int checks   = 0;
    int failures = 0;

    cpu_run_ctrl_if hif ();

    cpu_run_ctrl #(
        .RESET_CYCLES (2),
        .CW           (32),
        .TIMEOUT      (100)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .host_go       (host_go),
        .host          (hif.slave),
        .cpu_start     (cpu_start),
        .cpu_halt      (cpu_halt),
        .cpu_mem_addr  (cpu_mem_addr),
        .cpu_mem_read  (cpu_mem_read),
        .cpu_mem_write (cpu_mem_write),
        .cpu_mem_wdata (cpu_mem_wdata),
        .mem_addr      (mem_addr),
        .mem_read      (mem_read),
        .mem_write     (mem_write),
        .mem_wdata     (mem_wdata),
        .mem_rdata     (mem_rdata),
        .busy          (busy),
        .done          (done),
        .timeout       (timeout),
        .cycle_count   (cycle_count)
    );

    always #5 clk = ~clk;

    // Behavioural data memory: combinational read, write on the clock edge.
    logic [MEM_W-1:0] dmem [256];
    assign mem_rdata = dmem[mem_addr];
    always @(posedge clk) if (mem_write) dmem[mem_addr] <= mem_wdata;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Pulse go in a host state and walk through the two PRESET cycles into RUN.
    task automatic start_run();
        host_go = 1'b1;
        tick();
        host_go = 1'b0;
        check("preset1_busy", {31'd0, busy}, 32'd1);
        check("preset1_start", {31'd0, cpu_start}, 32'd1);
        tick();
        check("preset2_start", {31'd0, cpu_start}, 32'd1);
        tick();
        check("run_start_low", {31'd0, cpu_start}, 32'd0);
        check("run_count0", cycle_count, 32'd0);
    endtask

    initial begin
        for (int i = 0; i < 256; i++) dmem[i] = '0;
        reset              = 1'b1;
        host_go            = 1'b0;
        cpu_halt           = 1'b0;
        cpu_mem_addr       = '0;
        cpu_mem_read       = 1'b0;
        cpu_mem_write      = 1'b0;
        cpu_mem_wdata      = '0;
        hif.host_mem_req   = 1'b0;
        hif.host_mem_we    = 1'b0;
        hif.host_mem_addr  = '0;
        hif.host_mem_wdata = '0;
        tick();
        tick();

        // Reset state.
        check("rst_cpu_start", {31'd0, cpu_start}, 32'd1);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_timeout", {31'd0, timeout}, 32'd0);
        check("rst_ack", {31'd0, hif.host_mem_ack}, 32'd0);
        check("rst_rdata", {24'd0, hif.host_mem_rdata}, 32'd0);
        check("rst_count", cycle_count, 32'd0);
        check("rst_mem_idle", {30'd0, mem_read, mem_write}, 32'd0);
        reset = 1'b0;
        tick();

        // Host write 0x5A @0x10, then read back; no accept in the ack cycle.
        hif.host_mem_req   = 1'b1;
        hif.host_mem_we    = 1'b1;
        hif.host_mem_addr  = 8'h10;
        hif.host_mem_wdata = 8'h5A;
        #1;
        check("wr_mem_write", {31'd0, mem_write}, 32'd1);
        check("wr_mem_read", {31'd0, mem_read}, 32'd0);
        check("wr_mem_addr", {24'd0, mem_addr}, 32'h10);
        check("wr_mem_wdata", {24'd0, mem_wdata}, 32'h5A);
        check("wr_ack_early", {31'd0, hif.host_mem_ack}, 32'd0);
        tick();
        check("wr_ack", {31'd0, hif.host_mem_ack}, 32'd1);
        hif.host_mem_we = 1'b0;
        #1;
        check("ackcyc_no_read", {31'd0, mem_read}, 32'd0);
        check("ackcyc_no_write", {31'd0, mem_write}, 32'd0);
        check("ackcyc_addr0", {24'd0, mem_addr}, 32'd0);
        tick();
        check("rd_ack_low", {31'd0, hif.host_mem_ack}, 32'd0);
        check("rd_mem_read", {31'd0, mem_read}, 32'd1);
        check("rd_mem_addr", {24'd0, mem_addr}, 32'h10);
        tick();
        check("rd_ack", {31'd0, hif.host_mem_ack}, 32'd1);
        check("rd_rdata", {24'd0, hif.host_mem_rdata}, 32'h5A);
        hif.host_mem_req = 1'b0;
        tick();
        check("rd_ack_pulse", {31'd0, hif.host_mem_ack}, 32'd0);

        // Run halting after 37 counted cycles; a go pulse mid-run is ignored.
        start_run();
        repeat (10) tick();
        cpu_mem_write = 1'b1;
        cpu_mem_addr  = 8'h20;
        cpu_mem_wdata = 8'h77;
        host_go       = 1'b1;
        #1;
        check("run_pass_write", {31'd0, mem_write}, 32'd1);
        check("run_pass_addr", {24'd0, mem_addr}, 32'h20);
        check("run_pass_wdata", {24'd0, mem_wdata}, 32'h77);
        tick();
        host_go       = 1'b0;
        cpu_mem_write = 1'b0;
        cpu_mem_addr  = '0;
        cpu_mem_wdata = '0;
        check("go_ignored_busy", {31'd0, busy}, 32'd1);
        check("go_ignored_start", {31'd0, cpu_start}, 32'd0);
        check("run_count11", cycle_count, 32'd11);
        repeat (26) tick();
        check("run_count37", cycle_count, 32'd37);
        cpu_halt = 1'b1;
        tick();
        cpu_halt = 1'b0;
        check("halt_done", {31'd0, done}, 32'd1);
        check("halt_busy", {31'd0, busy}, 32'd0);
        check("halt_timeout", {31'd0, timeout}, 32'd0);
        check("halt_cpu_start", {31'd0, cpu_start}, 32'd1);
        check("halt_count", cycle_count, 32'd37);
        repeat (10) tick();
        check("frozen_count", cycle_count, 32'd37);
        check("frozen_done", {31'd0, done}, 32'd1);

        // Host request during RUN is held off until DONE, then unloads the result.
        start_run();
        hif.host_mem_req  = 1'b1;
        hif.host_mem_we   = 1'b0;
        hif.host_mem_addr = 8'h20;
        for (int i = 0; i < 5; i++) begin
            #1;
            check("run_req_no_ack", {31'd0, hif.host_mem_ack}, 32'd0);
            check("run_req_no_read", {31'd0, mem_read}, 32'd0);
            tick();
        end
        cpu_halt = 1'b1;
        tick();
        cpu_halt = 1'b0;
        check("run2_count", cycle_count, 32'd5);
        check("done_accept_read", {31'd0, mem_read}, 32'd1);
        check("done_accept_addr", {24'd0, mem_addr}, 32'h20);
        tick();
        check("done_ack", {31'd0, hif.host_mem_ack}, 32'd1);
        check("done_rdata", {24'd0, hif.host_mem_rdata}, 32'h77);
        hif.host_mem_req = 1'b0;
        tick();

        // go and req in the same host cycle: go wins, request served after the run.
        hif.host_mem_req  = 1'b1;
        hif.host_mem_we   = 1'b0;
        hif.host_mem_addr = 8'h10;
        host_go           = 1'b1;
        #1;
        check("go_req_no_read", {31'd0, mem_read}, 32'd0);
        tick();
        host_go = 1'b0;
        check("go_req_preset", {31'd0, busy}, 32'd1);
        check("go_req_no_ack", {31'd0, hif.host_mem_ack}, 32'd0);
        tick();
        tick();
        check("go_req_run", {31'd0, cpu_start}, 32'd0);
        repeat (3) tick();
        check("go_req_run_no_ack", {31'd0, hif.host_mem_ack}, 32'd0);
        cpu_halt = 1'b1;
        tick();
        cpu_halt = 1'b0;
        tick();
        check("go_req_ack", {31'd0, hif.host_mem_ack}, 32'd1);
        check("go_req_rdata", {24'd0, hif.host_mem_rdata}, 32'h5A);
        hif.host_mem_req = 1'b0;
        tick();

        // Non-halting program runs into the timeout; core writes are cut off.
        start_run();
        cpu_mem_write = 1'b1;
        cpu_mem_addr  = 8'h30;
        cpu_mem_wdata = 8'hEE;
        repeat (99) tick();
        check("to_count99", cycle_count, 32'd99);
        check("to_not_yet", {31'd0, timeout}, 32'd0);
        check("to_pass_write", {31'd0, mem_write}, 32'd1);
        tick();
        check("to_flag", {31'd0, timeout}, 32'd1);
        check("to_count100", cycle_count, 32'd100);
        check("to_cpu_start", {31'd0, cpu_start}, 32'd1);
        check("to_busy", {31'd0, busy}, 32'd0);
        for (int i = 0; i < 5; i++) begin
            check("to_write_blocked", {31'd0, mem_write}, 32'd0);
            tick();
        end
        cpu_mem_write = 1'b0;
        cpu_mem_addr  = '0;
        cpu_mem_wdata = '0;

        // Halt exactly at count TIMEOUT-1: DONE wins, no timeout.
        start_run();
        repeat (99) tick();
        check("edge_count99", cycle_count, 32'd99);
        cpu_halt = 1'b1;
        tick();
        cpu_halt = 1'b0;
        check("edge_done", {31'd0, done}, 32'd1);
        check("edge_timeout", {31'd0, timeout}, 32'd0);
        check("edge_count", cycle_count, 32'd99);

        // Reset in the middle of a run.
        start_run();
        repeat (20) tick();
        check("mid_count20", cycle_count, 32'd20);
        reset = 1'b1;
        tick();
        check("mid_rst_start", {31'd0, cpu_start}, 32'd1);
        check("mid_rst_count", cycle_count, 32'd0);
        check("mid_rst_busy", {31'd0, busy}, 32'd0);
        check("mid_rst_done", {31'd0, done}, 32'd0);
        reset = 1'b0;
        tick();
        check("mid_rst_idle", {29'd0, busy, done, timeout}, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
